mbox_req_seq: RTL and testbench

//  Parametrised EBOX->MBOX memory request sequencer; successor to the single-requester eboxReq/cshEBOXT0/cshEBOXRetry/mboxRespIn path.

---
 rtl/mbox_req_seq_if.sv | 45 ++++
 rtl/mbox_req_seq.sv | 150 +++++++++++++++
 tb/tb_mbox_req_seq.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mbox_req_seq_if.sv
// rtl/mbox_req_seq_if.sv - channel, MBOX and error signal bundle for mbox_req_seq
interface mbox_req_seq_if #(
  parameter int NCHAN  = 2,
  parameter int ADDR_W = 23,
  parameter int DATA_W = 36,
  parameter int NERR   = 5
);
  logic [NCHAN-1:0]        reqValid;
  logic [NCHAN-1:0]        reqWrite;
  logic [NCHAN*ADDR_W-1:0] reqAdr;
  logic [NCHAN*DATA_W-1:0] reqData;
  logic [NCHAN-1:0]        reqAccept;
  logic [NCHAN-1:0]        respValid;
  logic [DATA_W-1:0]       respData;
  logic                    respErr;

  logic                    mboxReq;
  logic [ADDR_W-1:0]       mboxAdr;
  logic                    mboxWrite;
  logic [DATA_W-1:0]       mboxData;
  logic                    cshT0;
  logic                    cshRetry;
  logic                    mboxRespIn;
  logic [DATA_W-1:0]       mboxRespData;

  logic [NERR-1:0]         errIn;
  logic                    errClear;
  logic [NERR+1:0]         errLatched;
  logic                    anyError;

  // master: the sequencer; slave: requesters, MBOX and error sources
  modport master (
    input  reqValid, reqWrite, reqAdr, reqData, cshT0, cshRetry, mboxRespIn,
           mboxRespData, errIn, errClear,
    output reqAccept, respValid, respData, respErr, mboxReq, mboxAdr, mboxWrite,
           mboxData, errLatched, anyError
  );

  modport slave (
    output reqValid, reqWrite, reqAdr, reqData, cshT0, cshRetry, mboxRespIn,
           mboxRespData, errIn, errClear,
    input  reqAccept, respValid, respData, respErr, mboxReq, mboxAdr, mboxWrite,
           mboxData, errLatched, anyError
  );
endinterface

// File: rtl/mbox_req_seq.sv
// rtl/mbox_req_seq.sv - round-robin EBOX/PF/channel to MBOX request sequencer with retry/timeout
module mbox_req_seq #(
  parameter int NCHAN     = 2,
  parameter int ADDR_W    = 23,
  parameter int DATA_W    = 36,
  parameter int NERR      = 5,
  parameter int MAX_RETRY = 4,
  parameter int TIMEOUT   = 15
) (
  input logic              clk,
  input logic              reset,
  mbox_req_seq_if.master   bus
);
  localparam int CW = (NCHAN > 1) ? $clog2(NCHAN) : 1;
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t            state, state_n;
  logic [CW-1:0]     last_grant, last_grant_n, grant, grant_n, pick;
  logic              pick_ok;
  logic [RW-1:0]     retry_cnt, retry_cnt_n;
  logic [TW-1:0]     to_cnt, to_cnt_n;
  logic              retry_last, abort_retry, abort_to, finish;
  logic [NCHAN-1:0]  req_accept_n, resp_valid_n;
  logic [DATA_W-1:0] resp_data_n, mbox_data_n;
  logic [ADDR_W-1:0] mbox_adr_n;
  logic              mbox_write_n, resp_err_n;
  logic [NERR+1:0]   err_latched_n;

  // Scan from the farthest candidate back to the nearest so the nearest wins.
  always_comb begin
    pick    = last_grant;
    pick_ok = 1'b0;
    for (int k = NCHAN; k >= 1; k--) begin
      if (bus.reqValid[(int'(last_grant) + k) % NCHAN]) begin
        pick    = CW'((int'(last_grant) + k) % NCHAN);
        pick_ok = 1'b1;
      end
    end
  end

  assign retry_last = (retry_cnt == RW'(MAX_RETRY - 1));

  always_comb begin
    state_n      = state;
    grant_n      = grant;
    last_grant_n = last_grant;
    retry_cnt_n  = retry_cnt;
    to_cnt_n     = to_cnt;
    req_accept_n = '0;
    resp_valid_n = '0;
    resp_data_n  = '0;
    resp_err_n   = 1'b0;
    mbox_adr_n   = bus.mboxAdr;
    mbox_write_n = bus.mboxWrite;
    mbox_data_n  = bus.mboxData;
    abort_retry  = 1'b0;
    abort_to     = 1'b0;
    finish       = 1'b0;
    case (state)
      IDLE: begin
        if (pick_ok) begin
          grant_n      = pick;
          mbox_adr_n   = bus.reqAdr[int'(pick)*ADDR_W +: ADDR_W];
          mbox_write_n = bus.reqWrite[pick];
          mbox_data_n  = bus.reqData[int'(pick)*DATA_W +: DATA_W];
          req_accept_n = NCHAN'(1) << pick;
          state_n      = REQ;
        end
      end
      REQ: begin
        if (bus.cshRetry) begin
          if (retry_last) abort_retry = 1'b1;
          else retry_cnt_n = retry_cnt + 1'b1;
        end else if (bus.cshT0) begin
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (bus.mboxRespIn) begin
          finish      = 1'b1;
          resp_data_n = bus.mboxWrite ? '0 : bus.mboxRespData;
        end else if (bus.cshRetry) begin
          if (retry_last) begin
            abort_retry = 1'b1;
          end else begin
            retry_cnt_n = retry_cnt + 1'b1;
            state_n     = REQ;
          end
        end else if (to_cnt == TW'(TIMEOUT - 1)) begin
          abort_to = 1'b1;
        end else begin
          to_cnt_n = to_cnt + 1'b1;
        end
      end
      DONE: begin
        last_grant_n = grant;
        retry_cnt_n  = '0;
        to_cnt_n     = '0;
        state_n      = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // Completion outputs are registered on the edge that enters DONE.
    if (finish || abort_retry || abort_to) begin
      state_n      = DONE;
      resp_valid_n = NCHAN'(1) << grant;
      resp_err_n   = abort_retry | abort_to;
    end
    err_latched_n = (bus.errClear ? '0 : bus.errLatched) | {abort_retry, abort_to, bus.errIn};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      last_grant     <= CW'(NCHAN - 1);
      grant          <= '0;
      retry_cnt      <= '0;
      to_cnt         <= '0;
      bus.reqAccept  <= '0;
      bus.respValid  <= '0;
      bus.respData   <= '0;
      bus.respErr    <= 1'b0;
      bus.mboxReq    <= 1'b0;
      bus.mboxAdr    <= '0;
      bus.mboxWrite  <= 1'b0;
      bus.mboxData   <= '0;
      bus.errLatched <= '0;
      bus.anyError   <= 1'b0;
    end else begin
      state          <= state_n;
      last_grant     <= last_grant_n;
      grant          <= grant_n;
      retry_cnt      <= retry_cnt_n;
      to_cnt         <= to_cnt_n;
      bus.reqAccept  <= req_accept_n;
      bus.respValid  <= resp_valid_n;
      bus.respData   <= resp_data_n;
      bus.respErr    <= resp_err_n;
      bus.mboxReq    <= (state_n == REQ);
      bus.mboxAdr    <= mbox_adr_n;
      bus.mboxWrite  <= mbox_write_n;
      bus.mboxData   <= mbox_data_n;
      bus.errLatched <= err_latched_n;
      bus.anyError   <= |bus.errLatched;
    end
  end
endmodule

// File: tb/tb_mbox_req_seq.sv
// tb/tb_mbox_req_seq.sv - directed self-checking bench for mbox_req_seq
module tb_mbox_req_seq;
  localparam int NCHAN = 2, AW = 23, DW = 36, NERR = 5;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [AW-1:0] ch_adr  [NCHAN];
  logic [DW-1:0] ch_data [NCHAN];
  logic          ch_wr   [NCHAN];

  mbox_req_seq_if #(.NCHAN(NCHAN), .ADDR_W(AW), .DATA_W(DW), .NERR(NERR)) bus ();

  mbox_req_seq #(.NCHAN(NCHAN), .ADDR_W(AW), .DATA_W(DW), .NERR(NERR),
                 .MAX_RETRY(4), .TIMEOUT(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_channels();
    for (int i = 0; i < NCHAN; i++) begin
      bus.reqAdr[i*AW +: AW]  = ch_adr[i];
      bus.reqData[i*DW +: DW] = ch_data[i];
      bus.reqWrite[i]         = ch_wr[i];
    end
  endtask

  task automatic wait_accept(input string tag, input logic [NCHAN-1:0] exp);
    int n = 0;
    while (bus.reqAccept == '0 && n < 8) begin
      step();
      n++;
    end
    chk(tag, 64'(bus.reqAccept), 64'(exp));
  endtask

  // One minimum-latency transaction on an already-granted-pending channel.
  task automatic txn(input int ch, input logic [DW-1:0] rd);
    wait_accept("t2_accept", NCHAN'(1) << ch);
    chk("t2_adr", 64'(bus.mboxAdr), 64'(ch_adr[ch]));
    chk("t2_write", 64'(bus.mboxWrite), 64'(ch_wr[ch]));
    if (ch_wr[ch]) chk("t2_wdata", 64'(bus.mboxData), 64'(ch_data[ch]));
    bus.cshT0 = 1'b1;
    step();
    bus.cshT0 = 1'b0;
    bus.mboxRespIn = 1'b1;
    bus.mboxRespData = rd;
    step();
    bus.mboxRespIn = 1'b0;
    chk("t2_resp_valid", 64'(bus.respValid), 64'(NCHAN'(1) << ch));
    chk("t2_resp_data", 64'(bus.respData), ch_wr[ch] ? 64'd0 : 64'(rd));
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.reqValid = '0; bus.reqWrite = '0; bus.reqAdr = '0; bus.reqData = '0;
    bus.cshT0 = 1'b0; bus.cshRetry = 1'b0; bus.mboxRespIn = 1'b0; bus.mboxRespData = '0;
    bus.errIn = '0; bus.errClear = 1'b0;
    ch_adr[0] = 23'h12345; ch_data[0] = 36'h0; ch_wr[0] = 1'b0;
    ch_adr[1] = 23'h7ABCD; ch_data[1] = 36'hF0F0F0F0F; ch_wr[1] = 1'b1;
    load_channels();
    step(); step();
    chk("rst_mbox_req", 64'(bus.mboxReq), 64'd0);
    chk("rst_accept", 64'(bus.reqAccept), 64'd0);
    chk("rst_resp_valid", 64'(bus.respValid), 64'd0);
    chk("rst_err_latched", 64'(bus.errLatched), 64'd0);
    chk("rst_any_error", 64'(bus.anyError), 64'd0);

    // 1: minimum-latency read on ch0
    reset = 1'b0;
    bus.reqValid = 2'b01;
    step();
    chk("t1_accept", 64'(bus.reqAccept), 64'h1);
    chk("t1_mbox_req", 64'(bus.mboxReq), 64'd1);
    chk("t1_adr", 64'(bus.mboxAdr), 64'h12345);
    bus.reqValid = '0;
    bus.cshT0 = 1'b1;
    step();
    chk("t1_req_drop", 64'(bus.mboxReq), 64'd0);
    chk("t1_accept_pulse", 64'(bus.reqAccept), 64'd0);
    bus.cshT0 = 1'b0;
    bus.mboxRespIn = 1'b1;
    bus.mboxRespData = 36'o123456701234;
    step();
    bus.mboxRespIn = 1'b0;
    chk("t1_resp_valid", 64'(bus.respValid), 64'h1);
    chk("t1_resp_data", 64'(bus.respData), 64'(36'o123456701234));
    chk("t1_resp_err", 64'(bus.respErr), 64'd0);
    step();
    chk("t1_resp_pulse", 64'(bus.respValid), 64'd0);

    // 2: both channels pending, grants alternate from ch0 after reset
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.reqValid = 2'b11;
    txn(0, 36'h123456789);
    txn(1, 36'h987654321);
    txn(0, 36'h0DEADBEEF);
    txn(1, 36'h111111111);
    bus.reqValid = '0;

    // 3: three retries then success
    bus.reqValid = 2'b01;
    wait_accept("t3_accept", 2'b01);
    bus.reqValid = '0;
    bus.cshRetry = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3_req_hold", 64'(bus.mboxReq), 64'd1);
    end
    bus.cshRetry = 1'b0;
    bus.cshT0 = 1'b1;
    step();
    chk("t3_wait", 64'(bus.mboxReq), 64'd0);
    bus.cshT0 = 1'b0;
    bus.mboxRespIn = 1'b1;
    bus.mboxRespData = 36'h00000ABCD;
    step();
    bus.mboxRespIn = 1'b0;
    chk("t3_resp_valid", 64'(bus.respValid), 64'h1);
    chk("t3_resp_err", 64'(bus.respErr), 64'd0);
    chk("t3_resp_data", 64'(bus.respData), 64'h00000ABCD);
    step();

    // 4: retry exhaustion
    bus.reqValid = 2'b01;
    wait_accept("t4_accept", 2'b01);
    bus.reqValid = '0;
    bus.cshRetry = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_req_hold", 64'(bus.mboxReq), 64'd1);
    end
    step();
    bus.cshRetry = 1'b0;
    chk("t4_resp_valid", 64'(bus.respValid), 64'h1);
    chk("t4_resp_err", 64'(bus.respErr), 64'd1);
    chk("t4_resp_data", 64'(bus.respData), 64'd0);
    chk("t4_err_latched", 64'(bus.errLatched), 64'h40);
    chk("t4_any_error_lag", 64'(bus.anyError), 64'd0);
    chk("t4_req_off", 64'(bus.mboxReq), 64'd0);
    step();
    chk("t4_any_error", 64'(bus.anyError), 64'd1);
    chk("t4_resp_pulse", 64'(bus.respValid), 64'd0);

    // 5: response timeout, then error clear behaviour
    bus.reqValid = 2'b01;
    wait_accept("t5_accept", 2'b01);
    bus.reqValid = '0;
    bus.cshT0 = 1'b1;
    step();
    bus.cshT0 = 1'b0;
    repeat (14) step();
    chk("t5_no_early_abort", 64'(bus.respValid), 64'd0);
    step();
    chk("t5_resp_valid", 64'(bus.respValid), 64'h1);
    chk("t5_resp_err", 64'(bus.respErr), 64'd1);
    chk("t5_err_latched", 64'(bus.errLatched), 64'h60);
    step();
    bus.errClear = 1'b1;
    step();
    chk("t5_cleared", 64'(bus.errLatched), 64'd0);
    chk("t5_any_error_lag", 64'(bus.anyError), 64'd1);
    bus.errIn = 5'b00100;
    step();
    chk("t5_set_beats_clear", 64'(bus.errLatched), 64'h04);
    bus.errClear = 1'b0;
    bus.errIn = 5'b00001;
    step();
    chk("t5_sticky", 64'(bus.errLatched), 64'h05);
    bus.errIn = '0;
    step();
    chk("t5_sticky_hold", 64'(bus.errLatched), 64'h05);
    bus.errClear = 1'b1;
    step();
    bus.errClear = 1'b0;
    step();
    chk("t5_any_error_off", 64'(bus.anyError), 64'd0);

    // 6: reset while waiting for a response
    bus.reqValid = 2'b10;
    wait_accept("t6_accept", 2'b10);
    bus.reqValid = '0;
    bus.cshT0 = 1'b1;
    step();
    bus.cshT0 = 1'b0;
    reset = 1'b1;
    step();
    chk("t6_mbox_req", 64'(bus.mboxReq), 64'd0);
    chk("t6_resp_valid", 64'(bus.respValid), 64'd0);
    chk("t6_accept", 64'(bus.reqAccept), 64'd0);
    reset = 1'b0;
    bus.reqValid = 2'b11;
    step();
    chk("t6_ch0_first", 64'(bus.reqAccept), 64'h1);
    chk("t6_adr", 64'(bus.mboxAdr), 64'h12345);

    // 7: retry beats T0 in REQ, retry from WAIT, response beats retry in WAIT
    bus.reqValid = '0;
    bus.cshT0 = 1'b1;
    bus.cshRetry = 1'b1;
    step();
    chk("t7_retry_beats_t0", 64'(bus.mboxReq), 64'd1);
    bus.cshRetry = 1'b0;
    step();
    chk("t7_wait", 64'(bus.mboxReq), 64'd0);
    bus.cshT0 = 1'b0;
    bus.cshRetry = 1'b1;
    step();
    chk("t7_wait_retry", 64'(bus.mboxReq), 64'd1);
    bus.cshRetry = 1'b0;
    bus.cshT0 = 1'b1;
    step();
    bus.cshT0 = 1'b0;
    bus.cshRetry = 1'b1;
    bus.mboxRespIn = 1'b1;
    bus.mboxRespData = 36'h0ABCDEF01;
    step();
    bus.cshRetry = 1'b0;
    bus.mboxRespIn = 1'b0;
    chk("t7_resp_valid", 64'(bus.respValid), 64'h1);
    chk("t7_resp_err", 64'(bus.respErr), 64'd0);
    chk("t7_resp_data", 64'(bus.respData), 64'h0ABCDEF01);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
